// File: rtl/bounce_bar_gen.sv
// Vertical bars bouncing across the horizontal scan, each with its own speed and colour channel.
// Build option BOUNCE_BLEND_EN: overlapping bars add per channel with saturation instead of lowest-index priority.
module bounce_bar_gen #(
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned NUM_BARS = 3,
    parameter int unsigned BAR_W    = 20,
    parameter int unsigned MAX_POS  = 620,
    parameter int unsigned TICK_DIV = 32768,
    parameter int unsigned COLOR_W  = 8,
    parameter int unsigned LEVEL    = 220
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                pause,
    input  logic [COORD_W-1:0]  pixel_x,
    output logic [COLOR_W-1:0]  out_r,
    output logic [COLOR_W-1:0]  out_g,
    output logic [COLOR_W-1:0]  out_b,
    output logic [NUM_BARS-1:0] bar_hit,
    output logic                tick
);

    localparam int unsigned        EXT_W    = COORD_W + 1;
    localparam int unsigned        CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [EXT_W-1:0]   MAX_E    = EXT_W'(MAX_POS);
    localparam logic [EXT_W-1:0]   BAR_E    = EXT_W'(BAR_W);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [CNT_W-1:0]   prescale;
    logic               step_now;
    logic [COORD_W-1:0] pos     [NUM_BARS];
    dir_t               dir     [NUM_BARS];
    logic [COORD_W-1:0] pos_nxt [NUM_BARS];
    dir_t               dir_nxt [NUM_BARS];
    logic [EXT_W-1:0]   up_sum  [NUM_BARS];
    logic [NUM_BARS-1:0] hit;
    logic [COLOR_W-1:0] chan_nxt [3];

    // Motion happens on the same edge that raises tick.
    assign step_now = !pause && (prescale == CNT_LAST);

    // Prescaler and tick pulse; pause freezes the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
            tick     <= 1'b0;
        end else if (pause) begin
            tick <= 1'b0;
        end else if (prescale == CNT_LAST) begin
            prescale <= '0;
            tick     <= 1'b1;
        end else begin
            prescale <= prescale + CNT_W'(1);
            tick     <= 1'b0;
        end
    end

    // Next position per bar: bar i moves i+1 pixels per tick and turns around without an idle tick.
    always_comb begin
        for (int i = 0; i < NUM_BARS; i++) begin
            up_sum[i]  = {1'b0, pos[i]} + EXT_W'(i + 1);
            pos_nxt[i] = pos[i];
            dir_nxt[i] = dir[i];
            if (dir[i] == DIR_UP) begin
                if (up_sum[i] <= MAX_E) begin
                    pos_nxt[i] = COORD_W'(up_sum[i]);
                end else begin
                    pos_nxt[i] = COORD_W'(MAX_POS);
                    dir_nxt[i] = DIR_DOWN;
                end
            end else begin
                if ({1'b0, pos[i]} >= EXT_W'(i + 1)) begin
                    pos_nxt[i] = pos[i] - COORD_W'(i + 1);
                end else begin
                    pos_nxt[i] = '0;
                    dir_nxt[i] = DIR_UP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                pos[i] <= '0;
                dir[i] <= DIR_UP;
            end
        end else if (step_now) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                pos[i] <= pos_nxt[i];
                dir[i] <= dir_nxt[i];
            end
        end
    end

    // Coverage test in one extra bit so a bar near the right edge cannot alias onto x=0.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_BARS; i++) begin
            hit[i] = ({1'b0, pixel_x} >= {1'b0, pos[i]}) &&
                     ({1'b0, pixel_x} <  ({1'b0, pos[i]} + BAR_E));
        end
    end

`ifdef BOUNCE_BLEND_EN
    localparam int unsigned SUM_W = COLOR_W + 4;

    logic [SUM_W-1:0] sum [3];

    // Additive blend per channel, clamped to full scale.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            sum[c] = '0;
        end
        for (int i = 0; i < NUM_BARS; i++) begin
            if (hit[i]) begin
                sum[i % 3] = sum[i % 3] + SUM_W'(LEVEL);
            end
        end
        for (int c = 0; c < 3; c++) begin
            chan_nxt[c] = (|sum[c][SUM_W-1:COLOR_W]) ? '1 : sum[c][COLOR_W-1:0];
        end
    end
`else
    localparam logic [COLOR_W-1:0] LEVEL_C = COLOR_W'(LEVEL);

    // Lowest-index hitting bar owns the pixel; scanning downward lets it overwrite the rest.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            chan_nxt[c] = '0;
        end
        for (int i = int'(NUM_BARS) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                for (int c = 0; c < 3; c++) begin
                    chan_nxt[c] = '0;
                end
                chan_nxt[i % 3] = LEVEL_C;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r   <= '0;
            out_g   <= '0;
            out_b   <= '0;
            bar_hit <= '0;
        end else if (enable) begin
            out_r   <= chan_nxt[0];
            out_g   <= chan_nxt[1];
            out_b   <= chan_nxt[2];
            bar_hit <= hit;
        end else begin
            out_r   <= '0;
            out_g   <= '0;
            out_b   <= '0;
            bar_hit <= '0;
        end
    end

endmodule

// File: tb/tb_bounce_bar_gen.sv
// Bench for bounce_bar_gen: two instances (4 bars / max 620, 2 bars / max 1015) tracked by a
// cycle-level model of bar positions; every cycle's outputs are compared against it.
module tb_bounce_bar_gen;

    localparam int NB = 4, NW = 2, BW = 20, LV = 220;
    localparam int MAXA = 620, MAXW = 1015, DIVA = 4, DIVW = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, pause, enable_w, pause_w;
    logic [9:0] pixel_x, pixel_w;
    logic [7:0] out_r, out_g, out_b, r_w, g_w, b_w;
    logic [3:0] bar_hit;
    logic [1:0] hit_w;
    logic       tick, tick_w;

    int errors = 0;
    int checks = 0;
    int apos[NB];
    bit aup[NB];
    int aact;
    int wpos[NW];
    bit wup[NW];
    int wact;
    bit mtick, mtick_w;

    always #5 clk = ~clk;

    bounce_bar_gen #(
        .COORD_W(10), .NUM_BARS(NB), .BAR_W(BW), .MAX_POS(MAXA),
        .TICK_DIV(DIVA), .COLOR_W(8), .LEVEL(LV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pause(pause), .pixel_x(pixel_x),
        .out_r(out_r), .out_g(out_g), .out_b(out_b), .bar_hit(bar_hit), .tick(tick)
    );

    bounce_bar_gen #(
        .COORD_W(10), .NUM_BARS(NW), .BAR_W(BW), .MAX_POS(MAXW),
        .TICK_DIV(DIVW), .COLOR_W(8), .LEVEL(LV)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .enable(enable_w), .pause(pause_w), .pixel_x(pixel_w),
        .out_r(r_w), .out_g(g_w), .out_b(b_w), .bar_hit(hit_w), .tick(tick_w)
    );

    // A bar reflects off either wall, landing exactly on the wall when the step overshoots.
    function automatic void bounce(input int p, input bit up, input int s, input int maxp,
                                   output int np, output bit nup);
        np  = p;
        nup = up;
        if (up) begin
            if (p + s > maxp) begin np = maxp; nup = 1'b0; end
            else np = p + s;
        end else begin
            if (p - s < 0) begin np = 0; nup = 1'b1; end
            else np = p - s;
        end
    endfunction

    function automatic logic [23:0] colour(input logic [3:0] h, input int n);
        int ch[3] = '{0, 0, 0};
`ifdef BOUNCE_BLEND_EN
        for (int i = 0; i < n; i++) if (h[i]) ch[i % 3] += LV;
        for (int c = 0; c < 3; c++) if (ch[c] > 255) ch[c] = 255;
`else
        for (int i = 0; i < n; i++) begin
            if (h[i]) begin
                ch[i % 3] = LV;
                break;
            end
        end
`endif
        return {8'(ch[0]), 8'(ch[1]), 8'(ch[2])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin apos[i] = 0; aup[i] = 1'b1; end
        for (int i = 0; i < NW; i++) begin wpos[i] = 0; wup[i] = 1'b1; end
        aact = 0;
        wact = 0;
    endtask

    // One clock: predict from pre-edge state, advance the model, compare all outputs.
    task automatic cycle();
        logic [3:0]  eh;
        logic [1:0]  ewh;
        logic [23:0] ec, ecw;
        int x, xw, np;
        bit nu;
        x  = int'(pixel_x);
        xw = int'(pixel_w);
        eh = '0;
        ewh = '0;
        for (int i = 0; i < NB; i++) eh[i] = (x >= apos[i]) && (x < apos[i] + BW);
        for (int i = 0; i < NW; i++) ewh[i] = (xw >= wpos[i]) && (xw < wpos[i] + BW);
        ec = enable ? colour(eh, NB) : 24'h0;
        if (!enable) eh = '0;
        ecw = colour({2'b00, ewh}, NW);
        @(posedge clk);
        mtick = 1'b0;
        if (!pause) begin
            aact++;
            if (aact % DIVA == 0) begin
                mtick = 1'b1;
                for (int i = 0; i < NB; i++) begin
                    bounce(apos[i], aup[i], i + 1, MAXA, np, nu);
                    apos[i] = np;
                    aup[i]  = nu;
                end
            end
        end
        mtick_w = 1'b0;
        if (!pause_w) begin
            wact++;
            if (wact % DIVW == 0) begin
                mtick_w = 1'b1;
                for (int i = 0; i < NW; i++) begin
                    bounce(wpos[i], wup[i], i + 1, MAXW, np, nu);
                    wpos[i] = np;
                    wup[i]  = nu;
                end
            end
        end
        #1;
        checks++;
        if (tick !== mtick) begin errors++; $display("FAIL tick: got %b want %b t=%0t", tick, mtick, $time); end
        checks++;
        if (bar_hit !== eh) begin errors++; $display("FAIL bar_hit: got %b want %b x=%0d t=%0t", bar_hit, eh, x, $time); end
        checks++;
        if ({out_r, out_g, out_b} !== ec) begin errors++; $display("FAIL rgb: got %h want %h x=%0d t=%0t", {out_r, out_g, out_b}, ec, x, $time); end
        checks++;
        if (tick_w !== mtick_w) begin errors++; $display("FAIL tick_w: got %b want %b t=%0t", tick_w, mtick_w, $time); end
        checks++;
        if (hit_w !== ewh) begin errors++; $display("FAIL hit_w: got %b want %b x=%0d t=%0t", hit_w, ewh, xw, $time); end
        checks++;
        if ({r_w, g_w, b_w} !== ecw) begin errors++; $display("FAIL rgb_w: got %h want %h t=%0t", {r_w, g_w, b_w}, ecw, $time); end
    endtask

    task automatic run_to_tick_a(output bit ok);
        int n = 0;
        do begin cycle(); n++; end while (!mtick && n < 50);
        ok = mtick;
    endtask

    task automatic run_to_tick_w(output bit ok);
        int n = 0;
        do begin cycle(); n++; end while (!mtick_w && n < 50);
        ok = mtick_w;
    endtask

    task automatic test_reset();
        logic [3:0] tab[5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
        enable = 1'b1; pause = 1'b0; enable_w = 1'b1; pause_w = 1'b0;
        pixel_x = 10'd5; pixel_w = 10'd5; rst_n = 1'b0;
        model_reset();
        #12 rst_n = 1'b1;
        repeat (2) cycle();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_r, out_g, out_b, bar_hit, tick, r_w, hit_w, tick_w} !== '0) begin
            errors++;
            $display("FAIL async_reset: got rgb=%h hit=%b tick=%b want all zero", {out_r, out_g, out_b}, bar_hit, tick);
        end
        model_reset();
        #1 rst_n = 1'b1;
        repeat (4) cycle();
        checks++;
        if (tick !== 1'b1) begin errors++; $display("FAIL first_tick: got %b want 1", tick); end
        pause = 1'b1;
        for (int x = 0; x < 5; x++) begin
            pixel_x = 10'(x);
            cycle();
            checks++;
            if (bar_hit !== tab[x]) begin errors++; $display("FAIL pos_after_tick x=%0d: got %b want %b", x, bar_hit, tab[x]); end
        end
    endtask

    task automatic test_overlap();
        logic [23:0] want;
`ifdef BOUNCE_BLEND_EN
        want = {8'd255, 8'd220, 8'd220};
`else
        want = {8'd220, 8'd0, 8'd0};
`endif
        pixel_x = 10'd5;
        cycle();
        checks++;
        if (bar_hit !== 4'b1111) begin errors++; $display("FAIL overlap_hit: got %b want 1111", bar_hit); end
        checks++;
        if ({out_r, out_g, out_b} !== want) begin errors++; $display("FAIL overlap_rgb: got %h want %h", {out_r, out_g, out_b}, want); end
        pause = 1'b0;
    endtask

    task automatic test_hit_edges();
        int xs[4] = '{99, 100, 119, 120};
        bit ws[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int n = 0;
        pixel_x = 10'd300;
        while (!(apos[0] == 100 && aup[0]) && n < 5000) begin cycle(); n++; end
        checks++;
        if (n >= 5000) begin errors++; $display("FAIL hit_edges_wait: got timeout want bar0 at 100"); end
        pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pixel_x = 10'(xs[k]);
            cycle();
            checks++;
            if (bar_hit[0] !== ws[k]) begin errors++; $display("FAIL hit_edge x=%0d: got %b want %b", xs[k], bar_hit[0], ws[k]); end
        end
        pause = 1'b0;
    endtask

    task automatic test_turnaround();
        int xs[6] = '{617, 618, 619, 620, 616, 617};
        bit ws[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int n = 0;
        bit ok;
        pixel_x = 10'd0;
        while (!(apos[2] == 618 && aup[2]) && n < 5000) begin cycle(); n++; end
        checks++;
        if (n >= 5000) begin errors++; $display("FAIL turn_wait: got timeout want bar2 at 618"); end
        for (int s = 0; s < 3; s++) begin
            if (s > 0) begin
                pause = 1'b0;
                run_to_tick_a(ok);
                checks++;
                if (!ok) begin errors++; $display("FAIL turn_tick: got no tick want tick"); end
            end
            pause = 1'b1;
            for (int k = 0; k < 2; k++) begin
                pixel_x = 10'(xs[2*s+k]);
                cycle();
                checks++;
                if (bar_hit[2] !== ws[2*s+k]) begin errors++; $display("FAIL turn_top s=%0d x=%0d: got %b want %b", s, xs[2*s+k], bar_hit[2], ws[2*s+k]); end
            end
        end
        pause = 1'b0;
    endtask

    task automatic test_turn_bottom();
        int xs[6] = '{0, 1, 0, 20, 1, 2};
        bit ws[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        int n = 0;
        bit ok;
        pixel_w = 10'd500;
        while (!(wpos[1] == 1 && !wup[1]) && n < 10000) begin cycle(); n++; end
        checks++;
        if (n >= 10000) begin errors++; $display("FAIL bottom_wait: got timeout want bar1 at 1 down"); end
        for (int s = 0; s < 3; s++) begin
            if (s > 0) begin
                pause_w = 1'b0;
                run_to_tick_w(ok);
                checks++;
                if (!ok) begin errors++; $display("FAIL bottom_tick: got no tick want tick"); end
            end
            pause_w = 1'b1;
            for (int k = 0; k < 2; k++) begin
                pixel_w = 10'(xs[2*s+k]);
                cycle();
                checks++;
                if (hit_w[1] !== ws[2*s+k]) begin errors++; $display("FAIL turn_bottom s=%0d x=%0d: got %b want %b", s, xs[2*s+k], hit_w[1], ws[2*s+k]); end
            end
        end
        pause_w = 1'b0;
    endtask

    task automatic test_wide_alias();
        int n = 0;
        pixel_w = 10'd500;
        while (!(wpos[0] == 1015 && wup[0]) && n < 10000) begin cycle(); n++; end
        checks++;
        if (n >= 10000) begin errors++; $display("FAIL alias_wait: got timeout want bar0 at 1015"); end
        pause_w = 1'b1;
        pixel_w = 10'd1023;
        cycle();
        checks++;
        if (hit_w[0] !== 1'b1 || r_w !== 8'd220) begin errors++; $display("FAIL alias_1023: got hit=%b r=%0d want 1 220", hit_w[0], r_w); end
        for (int x = 0; x <= 10; x++) begin
            pixel_w = 10'(x);
            cycle();
            checks++;
            if (hit_w[0] !== 1'b0 || r_w !== 8'd0) begin errors++; $display("FAIL alias_low x=%0d: got hit=%b r=%0d want 0 0", x, hit_w[0], r_w); end
        end
        pause_w = 1'b0;
    endtask

    task automatic test_enable_pause();
        int ticks = 0;
        int saved;
        pause = 1'b0;
        enable = 1'b0;
        pixel_x = 10'(apos[0]);
        cycle();
        checks++;
        if ({out_r, out_g, out_b, bar_hit} !== '0) begin errors++; $display("FAIL enable_off: got rgb=%h hit=%b want zero", {out_r, out_g, out_b}, bar_hit); end
        for (int k = 0; k < 8; k++) begin cycle(); if (tick === 1'b1) ticks++; end
        checks++;
        if (ticks !== 2) begin errors++; $display("FAIL enable_off_ticks: got %0d want 2", ticks); end
        enable = 1'b1;
        pause = 1'b1;
        saved = apos[0];
        ticks = 0;
        for (int k = 0; k < 10 * DIVA; k++) begin cycle(); if (tick === 1'b1) ticks++; end
        checks++;
        if (ticks !== 0) begin errors++; $display("FAIL pause_ticks: got %0d want 0", ticks); end
        pixel_x = 10'(saved);
        cycle();
        checks++;
        if (bar_hit[0] !== 1'b1) begin errors++; $display("FAIL pause_hold_in: got %b want 1", bar_hit[0]); end
        pixel_x = 10'(saved + BW);
        cycle();
        checks++;
        if (bar_hit[0] !== 1'b0) begin errors++; $display("FAIL pause_hold_out: got %b want 0", bar_hit[0]); end
        pause = 1'b0;
    endtask

    task automatic test_random();
        int v;
        for (int k = 0; k < 3000; k++) begin
            enable  = ($urandom_range(0, 9) != 0);
            pause   = ($urandom_range(0, 9) == 0);
            pause_w = ($urandom_range(0, 15) == 0);
            v = apos[$urandom_range(0, NB - 1)] + int'($urandom_range(0, 40)) - 10;
            if (v < 0) v = 0;
            if (v > 1023) v = 1023;
            pixel_x = 10'(v);
            pixel_w = 10'($urandom_range(0, 1023));
            cycle();
        end
        pause = 1'b0;
        pause_w = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_hit_edges();
        test_turnaround();
        test_enable_pause();
        test_wide_alias();
        test_turn_bottom();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bounce_bar_gen.md
Name: bounce_bar_gen

Overview:
- Parametrised successor to the single-band red line generator in the pixel pipeline.
- Drives NUM_BARS vertical bars that bounce independently across the horizontal scan.
- Each bar has its own speed and colour channel. Outputs are registered RGB for the VGA output stage.
- The block sits between the scan-coordinate counter and the colour mux.

Parameters:
- COORD_W, 10: width of pixel_x and of the bar position registers.
- NUM_BARS, 3: number of bars, legal range 1..8.
- BAR_W, 20: bar width in pixels, legal range 1..255.
- MAX_POS, 620: highest left-edge position a bar may reach; must be less than 2^COORD_W.
- TICK_DIV, 32768: clk cycles per motion tick, legal range 2..2^24.
- COLOR_W, 8: width of each colour channel.
- LEVEL, 220: intensity driven for a lit channel; must be less than 2^COLOR_W.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  active-video qualifier.
- pause  in  1  freezes bar motion while high.
- pixel_x  in  COORD_W  current horizontal scan coordinate.
- out_r  out  COLOR_W  red channel, registered.
- out_g  out  COLOR_W  green channel, registered.
- out_b  out  COLOR_W  blue channel, registered.
- bar_hit  out  NUM_BARS  per-bar coverage of the current pixel, registered.
- tick  out  1  one-cycle pulse on each motion step, registered.

Behaviour:
- Reset:
  - Asserting rst_n low clears everything immediately: prescaler=0, tick=0, out_r/g/b=0, bar_hit=0.
  - Every bar: pos_i=0, dir_i=up.
  - Reset may be asserted mid-frame or mid-tick. Outputs clear with no clk edge required.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick is 1 for exactly one cycle on the cycle after the count equals TICK_DIV-1. Bars update on that same edge.
  - While pause=1, the prescaler holds its value, tick=0, and bars hold.
- Motion per tick, for bar i with step s_i=i+1:
  - Up: if pos_i+s_i <= MAX_POS, then pos_i += s_i. Otherwise pos_i = MAX_POS and dir_i = down, in the same tick.
  - Down: if pos_i >= s_i, then pos_i -= s_i. Otherwise pos_i = 0 and dir_i = up, in the same tick.
  - No idle tick at turnaround. Arithmetic uses COORD_W+1 bits, so there is no wrap.
  - enable has no effect on motion.
- Hit:
  - hit_i = (pixel_x >= pos_i) && (pixel_x < pos_i + BAR_W).
  - Both edges are evaluated in COORD_W+1 bits, so a bar at MAX_POS near 2^COORD_W does not alias to x=0.
- Colour:
  - Bar i drives channel (i mod 3): 0=red, 1=green, 2=blue.
  - Channels with no hit drive 0.
- Latency:
  - out_r/g/b and bar_hit are registered; pixel_x to output is exactly 1 clk.
  - Outputs use the pos value present at the sampling edge.
- enable=0: the next cycle gives out_r/g/b=0 and bar_hit=0. Positions keep moving.
- Overlap with the macro off: lowest-index hitting bar wins. Only its channel is LEVEL; the other channels are 0.

Optional Feature:
- Macro BOUNCE_BLEND_EN.
- Defined:
  - Overlapping bars blend additively per channel.
  - Each channel = sum of LEVEL over all hitting bars mapped to it, saturating at 2^COLOR_W-1.
  - Different channels light simultaneously.
- Undefined: the lowest-index priority rule above applies. No adder logic is synthesised.
- bar_hit always reports every hitting bar, whether or not the macro is defined.

Test Plan:
- Reset check. Setup: TICK_DIV=4, NUM_BARS=3, enable=1, pixel_x=5, rst_n=0 mid-tick.
  - Required: outputs 0 immediately, with no clk edge.
  - After release: first tick pulse 4 cycles later. pos={1,2,3}. bar_hit=3'b111. Default build: out_r=220, out_g=0, out_b=0.
- Turnaround, MAX_POS=620. Bar 2 (step 3) at pos 618 moving up.
  - Required: next tick gives pos=620 and dir=down. Following tick gives 617.
  - Bar 1 at pos 1 moving down: next tick gives pos=0 and dir=up. Following tick gives 2.
- Hit edges, bar 0 at pos=100, BAR_W=20.
  - pixel_x=99 gives bar_hit[0]=0. pixel_x=100 gives 1. pixel_x=119 gives 1. pixel_x=120 gives 0.
  - Each result appears 1 cycle after pixel_x is applied.
- Enable and pause.
  - enable=0 with bars covering the pixel: the next cycle has all outputs 0, and pos still advances on tick.
  - pause=1 for 10 ticks' worth of cycles: no tick pulse, and pos is unchanged.
- Overlap, NUM_BARS=4. Bars 0 and 3 (both red) and bar 1 cover the pixel.
  - Default build: out_r=220, out_g=0.
  - BOUNCE_BLEND_EN build: out_r=255 (saturated), out_g=220.
- Wide-edge alias check, COORD_W=10, MAX_POS=1015, BAR_W=20. Bar at 1015.
  - pixel_x=1023 gives a hit. pixel_x=0..10 gives no hit.
